cache_blk_line_sched: RTL and testbench
=======================================

CACHE_BLK_LINE_SCHED -- requirements
Module: cache_blk_line_sched

Interface
REQ-001 SHALL have parameter X_ADDR_WDTH, default 12: pixel x-coordinate width.
REQ-002 SHALL have parameter Y_ADDR_WDTH, default 12: pixel y-coordinate width.
REQ-003 SHALL have parameter C_L_H_SIZE, default 3: log2 of cache-line width in pixels.
REQ-004 SHALL have parameter C_L_V_SIZE, default 2: log2 of cache-line height in rows.
REQ-005 SHALL have port clk, input, 1: sole clock; all flops on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port blk_valid, input, 1: block request present.
REQ-008 SHALL have port blk_ready, output, 1: block request accepted when high together with blk_valid.
REQ-009 SHALL have ports start_x and start_y, input, X_ADDR_WDTH and Y_ADDR_WDTH: block origin in pixels.
REQ-010 SHALL have ports blk_width and blk_height, input, 4 each: block extent minus one in pixels (inclusive end = start + extent).
REQ-011 SHALL have ports line_valid (output, 1) and line_ready (input, 1): cache-line output handshake.
REQ-012 SHALL have ports line_x and line_y, output, X_ADDR_WDTH-C_L_H_SIZE and Y_ADDR_WDTH-C_L_V_SIZE: cache-line index.
REQ-013 SHALL have port line_last, output, 1: marks the final line of the current block.
REQ-014 SHALL have port busy, output, 1: high from block acceptance until the last line handshake completes.

Function
REQ-015 SHALL implement FSM states IDLE and WALK; blk_ready = 1 only in IDLE.
REQ-016 On acceptance in IDLE, SHALL register first index x0 = start_x>>C_L_H_SIZE and y0 = start_y>>C_L_V_SIZE.
REQ-017 On acceptance, SHALL register last index x1 = (start_x+blk_width)>>C_L_H_SIZE and y1 = (start_y+blk_height)>>C_L_V_SIZE, with sums computed one bit wider than the coordinate.
REQ-018 SHALL clamp x1/y1 to the all-ones index when the widened sum exceeds the coordinate range (no wrap-around).
REQ-019 SHALL enter WALK with line_valid = 1 and (line_x, line_y) = (x0, y0) on the cycle after acceptance (1-cycle latency).
REQ-020 SHALL emit lines in raster order: x increments first; at x1, x returns to x0 and y increments.
REQ-021 SHALL hold line_x, line_y, line_last and line_valid stable while line_valid=1 and line_ready=0.
REQ-022 SHALL advance exactly one line per cycle in which line_valid and line_ready are both high; back-to-back throughput SHALL be one line per cycle.
REQ-023 SHALL assert line_last exactly when line_x = x1 and line_y = y1.
REQ-024 On the line_last handshake, SHALL return to IDLE, deassert line_valid and busy, and assert blk_ready in the next cycle.
REQ-025 A single-line block (x0 = x1, y0 = y1) SHALL produce one line with line_last = 1.
REQ-026 Every emitted line (x, y) SHALL satisfy (x<<C_L_H_SIZE) <= start_x+blk_width, ((x+1)<<C_L_H_SIZE) > start_x, and the same relations for y; every line satisfying them SHALL be emitted exactly once.

Reset
REQ-027 While reset is high, SHALL force state IDLE, blk_ready=1, line_valid=0, line_last=0, busy=0, line_x=0 and line_y=0.
REQ-028 Reset asserted mid-WALK SHALL abandon the block immediately with no further lines; the block SHALL NOT be resumed.

Configuration
REQ-029 With SCHED_LINE_COUNT_EN defined, SHALL add output line_count (16 bits, reset 0), incremented per line handshake, saturating at 0xFFFF, plus input count_clr (1 bit, synchronous clear that takes priority over increment).
REQ-030 Without SCHED_LINE_COUNT_EN, line_count, count_clr and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take FSM state encoding, the dimension width (4) and the line-count width (16) from shared package cache_sched_pkg, alongside the existing cache configuration constants.
REQ-032 SHALL compute first/last index, including clamping, in sub-module cache_line_range, instantiated once for x and once for y.

Verification
REQ-033 start=(0,0), extent=(7,3), line_ready=1 -> one line (0,0) with line_last; blk_ready returns 2 cycles after acceptance.
REQ-034 start=(5,2), extent=(7,3), line_ready=1 -> lines (0,0),(1,0),(0,1),(1,1) on consecutive cycles; last=1 on (1,1).
REQ-035 start=(4088,4093), extent=(15,15) -> x1 and y1 clamp to 511 and 1023; lines (511,1023) only, with line_last.
REQ-036 Same stimulus as REQ-034 with line_ready toggling 1,0,0,1,... -> outputs stable during stalls; same 4 lines in the same order.
REQ-037 Reset pulse while the third line is pending -> line_valid=0 and blk_ready=1 during reset; a new block afterwards walks correctly from its own first line.
REQ-038 SCHED_LINE_COUNT_EN defined: two REQ-034 blocks -> line_count=8; count_clr pulsed coincident with a handshake -> line_count=0.

Source files
------------

// File: rtl/cache_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_sched_pkg
//  Description : Shared cache configuration constants, block-dimension and
//                line-count widths, scheduler FSM state encoding and a
//                saturating-increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_sched_pkg;

    // Default cache geometry (pixels / rows per cache line, as log2)
    localparam int C_X_ADDR_WDTH_DEF = 12;
    localparam int C_Y_ADDR_WDTH_DEF = 12;
    localparam int C_L_H_SIZE_DEF    = 3;
    localparam int C_L_V_SIZE_DEF    = 2;

    // Block extent field width and line counter width
    localparam int C_DIM_WDTH        = 4;
    localparam int C_LINE_CNT_WDTH   = 16;

    // Line scheduler state encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } sched_state_t;

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic logic [C_LINE_CNT_WDTH-1:0] sat_inc(
        input logic [C_LINE_CNT_WDTH-1:0] i_val
    );
        return (&i_val) ? i_val : i_val + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_range.sv
`default_nettype none
// ============================================================================
//  Module      : cache_line_range
//  Description : Converts a pixel start coordinate and inclusive extent into
//                first and last cache-line indices along one axis. The end
//                coordinate is summed one bit wider so an overflow clamps the
//                last index to all-ones rather than wrapping to a low index.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_line_range
    import cache_sched_pkg::*;
#(
    parameter int ADDR_WDTH = 12,
    parameter int LOG2_SIZE = 3
) (
    input  logic [ADDR_WDTH-1:0]           i_start,
    input  logic [C_DIM_WDTH-1:0]          i_extent,
    output logic [ADDR_WDTH-LOG2_SIZE-1:0] o_first_idx,
    output logic [ADDR_WDTH-LOG2_SIZE-1:0] o_last_idx
);

    logic [ADDR_WDTH:0] w_end_sum;

    // First index is the start coordinate's line; last index saturates on overflow
    always_comb begin
        w_end_sum   = {1'b0, i_start} + {{(ADDR_WDTH + 1 - C_DIM_WDTH){1'b0}}, i_extent};
        o_first_idx = i_start[ADDR_WDTH-1:LOG2_SIZE];
        if (w_end_sum[ADDR_WDTH]) begin
            o_last_idx = '1;
        end else begin
            o_last_idx = w_end_sum[ADDR_WDTH-1:LOG2_SIZE];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_blk_line_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cache_blk_line_sched
//  Description : Accepts a pixel block request and emits, in raster order,
//                every cache-line index the block touches, one per handshake.
//                Optional feature macro SCHED_LINE_COUNT_EN adds a saturating
//                16-bit handshake counter (line_count) with a synchronous
//                clear input (count_clr).
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_blk_line_sched
    import cache_sched_pkg::*;
#(
    parameter int X_ADDR_WDTH = C_X_ADDR_WDTH_DEF,
    parameter int Y_ADDR_WDTH = C_Y_ADDR_WDTH_DEF,
    parameter int C_L_H_SIZE  = C_L_H_SIZE_DEF,
    parameter int C_L_V_SIZE  = C_L_V_SIZE_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              blk_valid,
    output logic                              blk_ready,
    input  logic [X_ADDR_WDTH-1:0]            start_x,
    input  logic [Y_ADDR_WDTH-1:0]            start_y,
    input  logic [C_DIM_WDTH-1:0]             blk_width,
    input  logic [C_DIM_WDTH-1:0]             blk_height,
    output logic                              line_valid,
    input  logic                              line_ready,
    output logic [X_ADDR_WDTH-C_L_H_SIZE-1:0] line_x,
    output logic [Y_ADDR_WDTH-C_L_V_SIZE-1:0] line_y,
    output logic                              line_last,
`ifdef SCHED_LINE_COUNT_EN
    output logic [C_LINE_CNT_WDTH-1:0]        line_count,
    input  logic                              count_clr,
`endif
    output logic                              busy
);

    localparam int C_XI_WDTH = X_ADDR_WDTH - C_L_H_SIZE;
    localparam int C_YI_WDTH = Y_ADDR_WDTH - C_L_V_SIZE;

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic                 w_accept;
    logic                 w_at_last;
    logic                 w_hs;

    logic [C_XI_WDTH-1:0] w_first_x;
    logic [C_XI_WDTH-1:0] w_last_x;
    logic [C_YI_WDTH-1:0] w_first_y;
    logic [C_YI_WDTH-1:0] w_last_y;

    logic [C_XI_WDTH-1:0] r_x0;
    logic [C_XI_WDTH-1:0] r_x1;
    logic [C_YI_WDTH-1:0] r_y1;
    logic [C_XI_WDTH-1:0] r_line_x;
    logic [C_YI_WDTH-1:0] r_line_y;

    cache_line_range #(
        .ADDR_WDTH   (X_ADDR_WDTH),
        .LOG2_SIZE   (C_L_H_SIZE)
    ) u_range_x (
        .i_start     (start_x),
        .i_extent    (blk_width),
        .o_first_idx (w_first_x),
        .o_last_idx  (w_last_x)
    );

    cache_line_range #(
        .ADDR_WDTH   (Y_ADDR_WDTH),
        .LOG2_SIZE   (C_L_V_SIZE)
    ) u_range_y (
        .i_start     (start_y),
        .i_extent    (blk_height),
        .o_first_idx (w_first_y),
        .o_last_idx  (w_last_y)
    );

    // Final line of the block is reached when both axes sit on their last index
    assign w_at_last = (r_line_x == r_x1) && (r_line_y == r_y1);
    assign w_hs      = line_valid && line_ready;
    assign line_x    = r_line_x;
    assign line_y    = r_line_y;

    // Next-state and handshake outputs; all outputs depend only on state and registers
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        blk_ready   = 1'b0;
        line_valid  = 1'b0;
        line_last   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WALK;
                end
            end
            ST_WALK: begin
                line_valid = 1'b1;
                busy       = 1'b1;
                line_last  = w_at_last;
                if (line_ready && w_at_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture block range on acceptance, then step the raster position per handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_line_x <= '0;
            r_line_y <= '0;
        end else if (w_accept) begin
            r_x0     <= w_first_x;
            r_x1     <= w_last_x;
            r_y1     <= w_last_y;
            r_line_x <= w_first_x;
            r_line_y <= w_first_y;
        end else if (w_hs && !w_at_last) begin
            if (r_line_x == r_x1) begin
                r_line_x <= r_x0;
                r_line_y <= r_line_y + 1'b1;
            end else begin
                r_line_x <= r_line_x + 1'b1;
            end
        end
    end

`ifdef SCHED_LINE_COUNT_EN
    logic [C_LINE_CNT_WDTH-1:0] r_line_count;

    assign line_count = r_line_count;

    // Saturating count of line handshakes; clear wins over a coincident increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_count <= '0;
        end else if (count_clr) begin
            r_line_count <= '0;
        end else if (w_hs) begin
            r_line_count <= sat_inc(r_line_count);
        end
    end
`else
    // Line counter not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_blk_line_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_blk_line_sched
//  Description : Self-checking bench for cache_blk_line_sched: directed
//                vector table, reset/counter sequences and random blocks
//                checked against a coverage-set reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_blk_line_sched;

    localparam int XW = 12;
    localparam int YW = 12;
    localparam int HS = 3;
    localparam int VS = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            blk_valid;
    logic            blk_ready;
    logic [XW-1:0]   start_x;
    logic [YW-1:0]   start_y;
    logic [3:0]      blk_width;
    logic [3:0]      blk_height;
    logic            line_valid;
    logic            line_ready;
    logic [XW-HS-1:0] line_x;
    logic [YW-VS-1:0] line_y;
    logic            line_last;
    logic            busy;
`ifdef SCHED_LINE_COUNT_EN
    logic [15:0]     line_count;
    logic            count_clr;
`endif

    cache_blk_line_sched #(
        .X_ADDR_WDTH (XW),
        .Y_ADDR_WDTH (YW),
        .C_L_H_SIZE  (HS),
        .C_L_V_SIZE  (VS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .start_x    (start_x),
        .start_y    (start_y),
        .blk_width  (blk_width),
        .blk_height (blk_height),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_x     (line_x),
        .line_y     (line_y),
        .line_last  (line_last),
`ifdef SCHED_LINE_COUNT_EN
        .line_count (line_count),
        .count_clr  (count_clr),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        int sx;
        int sy;
        int w;
        int h;
        int mode;   // 0: always ready, 1: ready 1,0,0,1 pattern, 2: random
        int exp_n;  // expected number of lines emitted
    } vec_t;

    int mx[$];
    int my[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: every line whose pixel span overlaps the block, in raster order
    task automatic build_model(input int sx, input int sy, input int w, input int h);
        int xs[$];
        int ys[$];
        mx.delete();
        my.delete();
        for (int x = 0; x < (1 << (XW - HS)); x++)
            if ((x << HS) <= sx + w && ((x + 1) << HS) > sx) xs.push_back(x);
        for (int y = 0; y < (1 << (YW - VS)); y++)
            if ((y << VS) <= sy + h && ((y + 1) << VS) > sy) ys.push_back(y);
        foreach (ys[j]) foreach (xs[i]) begin
            mx.push_back(xs[i]);
            my.push_back(ys[j]);
        end
    endtask

    task automatic run_block(input int sx, input int sy, input int w, input int h,
                             input int mode, output int nlines);
        int     idx;
        int     cyc;
        bit     done;
        bit     have_prev;
        bit     rdy;
        longint prev;
        build_model(sx, sy, w, h);
        @(negedge clk);
        chk("blk_ready_idle", blk_ready, 1);
        blk_valid  = 1'b1;
        start_x    = 12'(sx);
        start_y    = 12'(sy);
        blk_width  = 4'(w);
        blk_height = 4'(h);
        @(posedge clk);
        @(negedge clk);
        blk_valid = 1'b0;
        chk("valid_latency", line_valid, 1);
        chk("busy_walk", busy, 1);
        idx = 0; cyc = 0; done = 0; have_prev = 0; prev = 0;
        while (!done && cyc < 300) begin
            if (have_prev)
                chk("stall_hold", {line_x, line_y, line_last, line_valid}, prev);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            line_ready = rdy;
            if (!line_valid) begin
                chk("valid_until_last", line_valid, 1);
                done = 1;
            end else if (rdy) begin
                if (idx < mx.size()) begin
                    chk("line_x", line_x, mx[idx]);
                    chk("line_y", line_y, my[idx]);
                    chk("line_last", line_last, (idx == mx.size() - 1) ? 1 : 0);
                end else begin
                    chk("extra_line", idx, mx.size() - 1);
                end
                if (line_last) done = 1;
                idx++;
                have_prev = 0;
            end else begin
                have_prev = 1;
                prev = {line_x, line_y, line_last, line_valid};
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        line_ready = 1'b0;
        if (!done) chk("walk_timeout", 0, 1);
        chk("line_total_vs_model", idx, mx.size());
        chk("blk_ready_after_last", blk_ready, 1);
        chk("busy_after_last", busy, 0);
        chk("valid_after_last", line_valid, 0);
        nlines = idx;
    endtask

    initial begin
        vec_t vecs[4];
        int   n;
        int   sx, sy;
        vecs[0] = '{sx: 0,    sy: 0,    w: 7,  h: 3,  mode: 0, exp_n: 1};
        vecs[1] = '{sx: 5,    sy: 2,    w: 7,  h: 3,  mode: 0, exp_n: 4};
        vecs[2] = '{sx: 4088, sy: 4093, w: 15, h: 15, mode: 0, exp_n: 1};
        vecs[3] = '{sx: 5,    sy: 2,    w: 7,  h: 3,  mode: 1, exp_n: 4};

        reset = 1'b1; blk_valid = 1'b0; line_ready = 1'b0;
        start_x = '0; start_y = '0; blk_width = '0; blk_height = '0;
`ifdef SCHED_LINE_COUNT_EN
        count_clr = 1'b0;
`endif
        #12;
        chk("rst_blk_ready", blk_ready, 1);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_line_last", line_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_x", line_x, 0);
        chk("rst_line_y", line_y, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].sx, vecs[i].sy, vecs[i].w, vecs[i].h, vecs[i].mode, n);
            chk("vec_line_count", n, vecs[i].exp_n);
        end

        // Reset while the third line of a 4-line block is pending
        @(negedge clk);
        blk_valid = 1'b1; start_x = 12'd5; start_y = 12'd2; blk_width = 4'd7; blk_height = 4'd3;
        @(posedge clk);
        @(negedge clk);
        blk_valid  = 1'b0;
        line_ready = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        line_ready = 1'b0;
        chk("third_line_x", line_x, 0);
        chk("third_line_y", line_y, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_line_valid", line_valid, 0);
        chk("midrst_blk_ready", blk_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_line_last", line_last, 0);
        @(negedge clk);
        reset = 1'b0;
        line_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_resume", line_valid, 0);
        end
        line_ready = 1'b0;
        run_block(21, 9, 12, 6, 0, n);
        chk("after_rst_count", n, 6);

`ifdef SCHED_LINE_COUNT_EN
        @(negedge clk);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        chk("cnt_cleared", line_count, 0);
        run_block(5, 2, 7, 3, 0, n);
        run_block(5, 2, 7, 3, 0, n);
        chk("cnt_two_blocks", line_count, 8);
        @(negedge clk);
        blk_valid = 1'b1; start_x = 12'd0; start_y = 12'd0; blk_width = 4'd7; blk_height = 4'd3;
        @(posedge clk);
        @(negedge clk);
        blk_valid  = 1'b0;
        line_ready = 1'b1;
        count_clr  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        line_ready = 1'b0;
        count_clr  = 1'b0;
        chk("cnt_clr_priority", line_count, 0);
        chk("cnt_blk_done", line_valid, 0);
`endif

        // Random blocks, edge-biased every fourth one
        for (int i = 0; i < 30; i++) begin
            if (i % 4 == 0) begin
                sx = 4095 - int'($urandom_range(0, 20));
                sy = 4095 - int'($urandom_range(0, 20));
            end else begin
                sx = int'($urandom_range(0, 4095));
                sy = int'($urandom_range(0, 4095));
            end
            run_block(sx, sy, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 2, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
